// File: rtl/bmp_pkg.sv
// Shared constants, state type and byte-extraction helper for the BMP stream writer.
package bmp_pkg;

   localparam int unsigned BMP_HEADER_BYTES = 32'd54;
   localparam int unsigned BMP_DIB_SIZE     = 32'd40;
   localparam int unsigned BMP_BPP          = 32'd24;
   localparam int unsigned BMP_PPM          = 32'd2835;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_PIXEL  = 3'd2,
      ST_PAD    = 3'd3,
      ST_DONE   = 3'd4
   } bmp_state_e;

   // Little-endian byte 'sel' of a 32-bit header word.
   function automatic logic [7:0] le_byte(input logic [31:0] word, input logic [1:0] sel);
      return word[{sel, 3'd0} +: 8];
   endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational lookup of the 54-byte BMP file header. Every field from offset 2
// onward is 4-byte aligned relative to offset 2, so the header is treated as 13 words.
`include "global.vh"
module bmp_header_rom
   import bmp_pkg::*;
#(
   parameter int DIM_W = 16
) (
   input  logic [5:0]                 idx_i,
   input  logic [DIM_W-1:0]           width_i,
   input  logic [DIM_W-1:0]           height_i,
   input  logic [31:0]                image_size_i,
   input  logic [31:0]                file_size_i,
   output logic [`CHANNEL_SIZE-1:0]   byte_o
);

   logic [5:0]  rel_s;
   logic [31:0] word_s;

   assign rel_s = idx_i - 6'd2;

   // Select the header word that holds the requested byte.
   always_comb begin
      word_s = 32'd0;
      case (rel_s[5:2])
         4'd0:    word_s = file_size_i;
         4'd1:    word_s = 32'd0;
         4'd2:    word_s = BMP_HEADER_BYTES;
         4'd3:    word_s = BMP_DIB_SIZE;
         4'd4:    word_s = 32'(width_i);
         4'd5:    word_s = 32'(height_i);
         4'd6:    word_s = {16'(BMP_BPP), 16'd1};
         4'd7:    word_s = 32'd0;
         4'd8:    word_s = image_size_i;
         4'd9:    word_s = BMP_PPM;
         4'd10:   word_s = BMP_PPM;
         default: word_s = 32'd0;
      endcase
   end

   // Signature bytes first, then the little-endian word fields.
   always_comb begin
      if (idx_i == 6'd0) begin
         byte_o = 8'h42;
      end else if (idx_i == 6'd1) begin
         byte_o = 8'h4D;
      end else begin
         byte_o = le_byte(word_s, rel_s[1:0]);
      end
   end

endmodule

// File: rtl/global.vh
// Project-wide data widths shared by the image pipeline blocks.
`ifndef GLOBAL_VH
`define GLOBAL_VH
`define PIXEL_SIZE 24
`define CHANNEL_SIZE 8
`endif

// File: rtl/bmp_stream_writer.sv
// Streams a 24-bpp bottom-up BMP file (header, B/G/R pixel bytes, row padding)
// through a single registered output slot at up to one byte per cycle.
`include "global.vh"
module bmp_stream_writer
   import bmp_pkg::*;
#(
   parameter int DIM_W = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      en,
   input  logic                      start,
   input  logic [DIM_W-1:0]          width,
   input  logic [DIM_W-1:0]          height,
   input  logic                      pix_valid,
   output logic                      pix_ready,
   input  logic [`PIXEL_SIZE-1:0]    pix_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [`CHANNEL_SIZE-1:0]  out_data,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done
);

   localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};
   localparam logic [DIM_W-1:0] DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
   localparam logic [5:0]       HDR_LAST = 6'(BMP_HEADER_BYTES - 32'd1);
   localparam int               BUF_W    = `PIXEL_SIZE - `CHANNEL_SIZE;

   bmp_state_e               state_q, state_d;
   logic [DIM_W-1:0]         width_q, width_d, height_q, height_d;
   logic [DIM_W-1:0]         col_q, col_d, row_q, row_d;
   logic [31:0]              image_size_q, image_size_d, file_size_q, file_size_d;
   logic                     empty_q, empty_d;
   logic [5:0]               hdr_idx_q, hdr_idx_d;
   logic [BUF_W-1:0]         pix_buf_q, pix_buf_d;
   logic [1:0]               pix_left_q, pix_left_d, pad_left_q, pad_left_d;
   logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [`CHANNEL_SIZE-1:0] out_data_q, out_data_d;
   logic                     busy_q, done_q;

   logic                     consume_s, slot_free_s, pix_ready_s, row_end_s, last_row_s;
   logic [31:0]              area_s;
   logic [`CHANNEL_SIZE-1:0] hdr_byte_s;

   assign consume_s   = en && out_valid_q && out_ready;
   assign slot_free_s = !out_valid_q || out_ready;
   assign row_end_s   = (col_q == width_q);
   assign last_row_s  = (row_q == height_q - DIM_ONE);
   assign area_s      = (32'(width) * 32'd3 + {30'd0, width[1:0]}) * 32'(height);

   bmp_header_rom #(.DIM_W(DIM_W)) u_hdr (
      .idx_i        (hdr_idx_q),
      .width_i      (width_q),
      .height_i     (height_q),
      .image_size_i (image_size_q),
      .file_size_i  (file_size_q),
      .byte_o       (hdr_byte_s)
   );

   // Next-state, counter and output-slot logic; nothing moves while en is low.
   always_comb begin
      state_d      = state_q;
      width_d      = width_q;
      height_d     = height_q;
      col_d        = col_q;
      row_d        = row_q;
      image_size_d = image_size_q;
      file_size_d  = file_size_q;
      empty_d      = empty_q;
      hdr_idx_d    = hdr_idx_q;
      pix_buf_d    = pix_buf_q;
      pix_left_d   = pix_left_q;
      pad_left_d   = pad_left_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_data_d   = out_data_q;
      pix_ready_s  = 1'b0;
      if (en) begin
         if (consume_s) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
         end
         if (out_last_q) begin
            // The final byte is parked in the slot; the frame ends once it is taken.
            if (consume_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = state_q;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     width_d      = width;
                     height_d     = height;
                     image_size_d = area_s;
                     file_size_d  = area_s + BMP_HEADER_BYTES;
                     empty_d      = (width == DIM_ZERO) || (height == DIM_ZERO);
                     hdr_idx_d    = 6'd0;
                     col_d        = DIM_ZERO;
                     row_d        = DIM_ZERO;
                     pix_left_d   = 2'd0;
                     pad_left_d   = 2'd0;
                     state_d      = ST_HEADER;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               ST_HEADER: begin
                  if (slot_free_s) begin
                     out_data_d  = hdr_byte_s;
                     out_valid_d = 1'b1;
                     hdr_idx_d   = hdr_idx_q + 6'd1;
                     if (hdr_idx_q == HDR_LAST) begin
                        if (empty_q) begin
                           out_last_d = 1'b1;
                        end else begin
                           state_d = ST_PIXEL;
                        end
                     end else begin
                        state_d = ST_HEADER;
                     end
                  end else begin
                     state_d = ST_HEADER;
                  end
               end
               ST_PIXEL: begin
                  if (slot_free_s) begin
                     if (pix_left_q == 2'd0) begin
                        pix_ready_s = 1'b1;
                        if (pix_valid) begin
                           out_data_d  = pix_data[`CHANNEL_SIZE-1:0];
                           pix_buf_d   = pix_data[`PIXEL_SIZE-1:`CHANNEL_SIZE];
                           pix_left_d  = 2'd2;
                           out_valid_d = 1'b1;
                           col_d       = col_q + DIM_ONE;
                        end else begin
                           pix_left_d = 2'd0;
                        end
                     end else begin
                        out_data_d  = pix_buf_q[`CHANNEL_SIZE-1:0];
                        pix_buf_d   = {{`CHANNEL_SIZE{1'b0}}, pix_buf_q[BUF_W-1:`CHANNEL_SIZE]};
                        pix_left_d  = pix_left_q - 2'd1;
                        out_valid_d = 1'b1;
                        // Red byte of the row's final pixel: pad, next row, or end of file.
                        if ((pix_left_q == 2'd1) && row_end_s) begin
                           if (width_q[1:0] != 2'd0) begin
                              pad_left_d = width_q[1:0];
                              state_d    = ST_PAD;
                           end else begin
                              col_d = DIM_ZERO;
                              if (last_row_s) begin
                                 out_last_d = 1'b1;
                              end else begin
                                 row_d = row_q + DIM_ONE;
                              end
                           end
                        end else begin
                           state_d = ST_PIXEL;
                        end
                     end
                  end else begin
                     state_d = ST_PIXEL;
                  end
               end
               ST_PAD: begin
                  if (slot_free_s) begin
                     out_data_d  = {`CHANNEL_SIZE{1'b0}};
                     out_valid_d = 1'b1;
                     pad_left_d  = pad_left_q - 2'd1;
                     if (pad_left_q == 2'd1) begin
                        col_d = DIM_ZERO;
                        if (last_row_s) begin
                           out_last_d = 1'b1;
                        end else begin
                           row_d   = row_q + DIM_ONE;
                           state_d = ST_PIXEL;
                        end
                     end else begin
                        state_d = ST_PAD;
                     end
                  end else begin
                     state_d = ST_PAD;
                  end
               end
               ST_DONE: state_d = ST_IDLE;
               default: state_d = ST_IDLE;
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         width_q      <= DIM_ZERO;
         height_q     <= DIM_ZERO;
         col_q        <= DIM_ZERO;
         row_q        <= DIM_ZERO;
         image_size_q <= 32'd0;
         file_size_q  <= 32'd0;
         empty_q      <= 1'b0;
         hdr_idx_q    <= 6'd0;
         pix_buf_q    <= {BUF_W{1'b0}};
         pix_left_q   <= 2'd0;
         pad_left_q   <= 2'd0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= {`CHANNEL_SIZE{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         width_q      <= width_d;
         height_q     <= height_d;
         col_q        <= col_d;
         row_q        <= row_d;
         image_size_q <= image_size_d;
         file_size_q  <= file_size_d;
         empty_q      <= empty_d;
         hdr_idx_q    <= hdr_idx_d;
         pix_buf_q    <= pix_buf_d;
         pix_left_q   <= pix_left_d;
         pad_left_q   <= pad_left_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
         busy_q       <= (state_d != ST_IDLE);
         done_q       <= (state_d == ST_DONE);
      end
   end

   assign pix_ready = pix_ready_s && reset_n;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Randomised self-checking bench: a byte-queue model of the BMP file is built from
// width/height/pixels and compared against every transferred byte.
module tb_bmp_stream_writer;

   logic        clk = 1'b0;
   logic        reset_n, en, start, pix_valid, pix_ready, out_valid, out_ready, out_last, busy, done;
   logic [15:0] width, height;
   logic [23:0] pix_data;
   logic [7:0]  out_data;

   always #5 clk = ~clk;

   bmp_stream_writer #(.DIM_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .en(en), .start(start),
      .width(width), .height(height),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   int          checks = 0;
   int          errors = 0;
   byte unsigned exp_q[$];
   logic [23:0] pix_q[$];
   int          pix_idx = 0;
   int          done_cnt = 0;
   logic        chk_on = 1'b0;
   logic        prev_stall = 1'b0;
   logic        prev_last = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push32(input logic [31:0] v);
      for (int k = 0; k < 4; k++) exp_q.push_back(v[8*k +: 8]);
   endfunction

   // Reference BMP file from the format rules: header, rows of B,G,R, zero pad to 4 bytes.
   task automatic build_model(input int w, input int h);
      int pad, image;
      logic [23:0] p;
      pad   = w % 4;
      image = (3 * w + pad) * h;
      exp_q.delete();
      exp_q.push_back(8'h42); exp_q.push_back(8'h4D);
      push32(32'(54 + image)); push32(32'd0); push32(32'd54);
      push32(32'd40); push32(32'(w)); push32(32'(h));
      exp_q.push_back(8'd1); exp_q.push_back(8'd0); exp_q.push_back(8'd24); exp_q.push_back(8'd0);
      push32(32'd0); push32(32'(image)); push32(32'd2835); push32(32'd2835);
      push32(32'd0); push32(32'd0);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            p = pix_q[r * w + c];
            exp_q.push_back(p[7:0]); exp_q.push_back(p[15:8]); exp_q.push_back(p[23:16]);
         end
         for (int k = 0; k < pad; k++) exp_q.push_back(8'h00);
      end
   endtask

   task automatic prepare(input int w, input int h);
      pix_q.delete();
      for (int i = 0; i < w * h; i++) pix_q.push_back(24'($urandom));
      build_model(w, h);
   endtask

   // Compare process: every transferred byte, stall stability, stray pix_ready and done.
   always @(negedge clk) begin
      if (chk_on) begin
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_last", 32'(out_last), 32'(prev_last));
         end
         if (en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_byte actual=0x%0h expected=none at %0t", out_data, $time);
            end else begin
               check("byte", 32'(out_data), 32'(exp_q.pop_front()));
               check("last", 32'(out_last), 32'(exp_q.size() == 0));
            end
         end
         if (pix_idx >= pix_q.size()) check("pix_ready_none_due", 32'(pix_ready), 32'd0);
         if (done) begin
            done_cnt++;
            check("done_after_last", 32'(exp_q.size()), 32'd0);
         end
         prev_stall <= out_valid && !(en && out_ready);
         prev_data  <= out_data;
         prev_last  <= out_last;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   task automatic drive(input int mode, input bit en_stall, input int cyc);
      case (mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (en_stall)       en = !(cyc >= 80 && cyc < 85);
      else if (mode == 2) en = ($urandom_range(0, 7) != 0);
      else                en = 1'b1;
      pix_valid = (pix_idx < pix_q.size()) && (mode == 0 || $urandom_range(0, 3) != 0);
      pix_data  = (pix_idx < pix_q.size()) ? pix_q[pix_idx] : 24'($urandom);
      start     = (exp_q.size() > 8) && ($urandom_range(0, 1) == 1);
      width     = 16'($urandom);
      height    = 16'($urandom);
   endtask

   task automatic run_frame(input int w, input int h, input int mode, input bit en_stall, input int abort_at);
      int cyc, total;
      bit fin, pacc;
      total = exp_q.size();
      pix_idx = 0; done_cnt = 0;
      start = 1'b1; width = 16'(w); height = 16'(h); en = 1'b1; out_ready = 1'b1; pix_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; chk_on = 1'b1; cyc = 0; fin = 1'b0;
      drive(mode, en_stall, cyc);
      while (!fin) begin
         @(negedge clk);
         if (cyc == 0) check("busy_after_start", 32'(busy), 32'd1);
         pacc = en && pix_valid && pix_ready;
         if (done) fin = 1'b1;
         else if (cyc >= 4000) begin
            checks++; errors++; fin = 1'b1;
            $display("FAIL frame_timeout actual=%0d cycles expected=done w=%0d h=%0d", cyc, w, h);
         end else if (abort_at != 0 && cyc == abort_at) fin = 1'b1;
         if (!fin) begin
            @(posedge clk); #1;
            cyc++;
            if (pacc) pix_idx++;
            drive(mode, en_stall, cyc);
         end
      end
      if (abort_at != 0) begin
         chk_on = 1'b0; reset_n = 1'b0;
         @(posedge clk); #1;
         reset_n = 1'b1; en = 1'b1; out_ready = 1'b1; pix_valid = 1'b1; start = 1'b0;
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_pix_ready", 32'(pix_ready), 32'd0);
         check("rst_out_data", 32'(out_data), 32'd0);
         check("rst_out_last", 32'(out_last), 32'd0);
         check("rst_done", 32'(done), 32'd0);
         repeat (4) begin
            @(negedge clk);
            check("no_bytes_after_reset", 32'(out_valid), 32'd0);
         end
      end else begin
         if (mode == 0 && !en_stall) check("full_rate_cycles", 32'(cyc), 32'(total + 1));
         start = 1'b0; en = 1'b1; out_ready = 1'b1; pix_valid = 1'b0;
         repeat (3) @(negedge clk);
         check("done_pulses", 32'(done_cnt), 32'd1);
         check("bytes_left", 32'(exp_q.size()), 32'd0);
         check("pixels_taken", 32'(pix_idx), 32'(w * h));
         check("busy_end", 32'(busy), 32'd0);
         chk_on = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset_n = 1'b0; en = 1'b0; start = 1'b0; out_ready = 1'b0; pix_valid = 1'b0;
      width = 16'd0; height = 16'd0; pix_data = 24'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_out_last", 32'(out_last), 32'd0);
      check("reset_pix_ready", 32'(pix_ready), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      prepare(2, 2);
      check("m22_size", 32'(exp_q.size()), 32'd70);
      check("m22_b0", 32'(exp_q[0]), 32'h42);
      check("m22_b1", 32'(exp_q[1]), 32'h4D);
      check("m22_b2", 32'(exp_q[2]), 32'h46);
      check("m22_b3_5", 32'({exp_q[3], exp_q[4], exp_q[5]}), 32'd0);
      check("m22_b34", 32'(exp_q[34]), 32'h10);
      check("m22_pad", 32'({exp_q[60], exp_q[61], exp_q[68], exp_q[69]}), 32'd0);
      run_frame(2, 2, 0, 1'b0, 0);

      prepare(4, 1);
      pix_q[0] = 24'h112233;
      build_model(4, 1);
      check("m41_size", 32'(exp_q.size()), 32'd66);
      check("m41_pix", 32'({exp_q[54], exp_q[55], exp_q[56]}), 32'h332211);
      check("m41_fsize", 32'({exp_q[5], exp_q[4], exp_q[3], exp_q[2]}), 32'd66);
      run_frame(4, 1, 0, 1'b0, 0);

      prepare(3, 2);
      run_frame(3, 2, 1, 1'b0, 0);

      prepare(5, 3);
      run_frame(5, 3, 0, 1'b1, 0);

      prepare(0, 5);
      check("m05_size", 32'(exp_q.size()), 32'd54);
      check("m05_fsize", 32'({exp_q[5], exp_q[4], exp_q[3], exp_q[2]}), 32'd54);
      check("m05_isize", 32'({exp_q[37], exp_q[36], exp_q[35], exp_q[34]}), 32'd0);
      run_frame(0, 5, 2, 1'b0, 0);

      prepare(7, 0);
      run_frame(7, 0, 2, 1'b0, 0);

      for (int f = 0; f < 6; f++) begin
         int w, h;
         w = $urandom_range(0, 9);
         h = $urandom_range(0, 4);
         prepare(w, h);
         run_frame(w, h, 2, 1'b0, 0);
      end

      prepare(6, 4);
      run_frame(6, 4, 0, 1'b0, 65);

      prepare(1, 1);
      check("m11_size", 32'(exp_q.size()), 32'd58);
      run_frame(1, 1, 0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
